// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller in front of a word-only data memory.
// Byte/halfword/word CPU accesses become whole-word memory transactions;
// loads extract and extend the addressed lane, sub-word stores run a
// read-modify-write (RMW_RD -> STORE).
// Optional feature macro: LSU_MISALIGN_CHECK_EN (defined = reject misaligned
// accesses with a done+misalign pulse; undefined = ignore low address bits).
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] DataAddr,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  input  logic [31:0] ReadData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RMW_RD = 2'd2,
    S_STORE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sx_q, sx_d;
  logic [15:0] wlow_q, wlow_d;      // only the low halfword is needed for RMW merges
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wr_q, wr_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        mis_s;

  // Pick the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lo,
                                               input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/halfword of a word with new store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lo,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    case (sz)
      2'b00: begin
        case (lo)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          2'd3:    r[31:24] = wd[7:0];
          default: r        = word;
        endcase
      end
      2'b01: begin
        if (lo[1]) r[31:16] = wd;
        else       r[15:0]  = wd;
      end
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  // Halfword needs addr[0]=0, word (size 1x) needs addr[1:0]=00.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = lo[0];
      default: m = (lo != 2'b00);
    endcase
    return m;
  endfunction

  assign mis_s = is_misaligned(size, addr[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  // Next-state and datapath decisions for the access sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sx_d    = sx_q;
    wlow_d  = wlow_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = addr;
          size_d = size;
          sx_d   = sign_ext;
          wlow_d = wdata[15:0];
          if (mis_s) begin
            done_d  = 1'b1;
            mis_d   = 1'b1;
            state_d = S_IDLE;
          end else if (!we) begin
            state_d = S_LOAD;
          end else if (size[1]) begin
            wr_d    = wdata;
            state_d = S_STORE;
          end else begin
            state_d = S_RMW_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        rdata_d = load_extract(ReadData, size_q, addr_q[1:0], sx_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RMW_RD: begin
        wr_d    = store_merge(ReadData, size_q, addr_q[1:0], wlow_q);
        state_d = S_STORE;
      end
      S_STORE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0000_0000;
      size_q  <= 2'b00;
      sx_q    <= 1'b0;
      wlow_q  <= 16'h0000;
      rdata_q <= 32'h0000_0000;
      wr_q    <= 32'h0000_0000;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sx_q    <= sx_d;
      wlow_q  <= wlow_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign MemWrite  = (state_q == S_STORE);
  assign done      = done_q;
  assign misalign  = mis_q;
  assign rdata     = rdata_q;
  assign WriteData = wr_q;
  assign DataAddr  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural word memory.
module tb_lsu_ctrl;

  logic        clk, rst, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, MemWrite;
  logic [31:0] rdata, DataAddr, WriteData, ReadData;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          wr_cnt;
  logic [31:0] last_wr_addr, last_wr_data;
  logic [31:0] last_rd;

  typedef struct packed {
    logic        mis;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .DataAddr(DataAddr), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ReadData = mem[DataAddr[11:2]];

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[DataAddr[11:2]] <= WriteData;
      wr_cnt              <= wr_cnt + 1;
      last_wr_addr        <= DataAddr;
      last_wr_data        <= WriteData;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int lane_shift(input logic [1:0] sz, input logic [1:0] lo);
    if (sz == 2'd0)      return int'(lo) * 8;
    else if (sz == 2'd1) return int'(lo[1]) * 16;
    else                 return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic sx);
    logic [31:0] v;
    logic signed [31:0] t;
    int keep;
    v = w >> lane_shift(sz, lo);
    keep = (sz == 2'd0) ? 24 : (sz == 2'd1) ? 16 : 0;
    t = v << keep;
    if (sx) t = t >>> keep;
    else    t = $signed(32'(v << keep) >> keep);
    return t;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    sh = lane_shift(sz, lo);
    m  = (sz == 2'd0) ? (32'h0000_00FF << sh) : (sz == 2'd1) ? (32'h0000_FFFF << sh) : 32'hFFFF_FFFF;
    return (w & ~m) | ((wd << sh) & m);
  endfunction

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    return (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[11:2]]     = v;
    ref_mem[a[11:2]] = v;
  endtask

  // Compute the expectation, push it, and update the reference state.
  function automatic exp_t predict(input logic w, input logic [1:0] sz, input logic sx,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.mis = model_mis(sz, a);
    if (!e.mis && !w) last_rd = model_load(ref_mem[a[11:2]], sz, a[1:0], sx);
    else if (!e.mis)  ref_mem[a[11:2]] = model_store(ref_mem[a[11:2]], sz, a[1:0], wd);
    e.rd = last_rd;
    return e;
  endfunction

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    int n, lat_exp;
    exp_t e;
    e = predict(w, sz, sx, a, wd);
    lat_exp = e.mis ? 0 : (!w ? 1 : (sz[1] ? 1 : 2));
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat_exp));
    check("busy_in_done", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("misalign", {31'd0, misalign}, {31'd0, e.mis});
        check("rdata", rdata, e.rd);
      end
    end else if (!rst && misalign) begin
      check("misalign_without_done", 32'd1, 32'd0);
    end
  end

  initial begin
    int wc;
    exp_t e;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0; wr_cnt = 0; last_wr_addr = 32'h0; last_wr_data = 32'h0;
    last_rd = 32'h0;
    for (int i = 0; i < 1024; i++) preload(32'(i * 4), 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dataaddr", DataAddr, 32'h0);
    check("rst_writedata", WriteData, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word store then load
    wc = wr_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("ws_wr_count", 32'(wr_cnt - wc), 32'd1);
    check("ws_wr_addr", last_wr_addr, 32'h10);
    check("ws_mem", mem[4], 32'hDEAD_BEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("wl_rdata", rdata, 32'hDEAD_BEEF);

    // Sub-word store via RMW
    preload(32'h20, 32'h1122_3344);
    access(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AB);
    check("rmw_wdata", last_wr_data, 32'h11AB_3344);
    check("rmw_mem", mem[8], 32'h11AB_3344);
    check("rmw_rdata_kept", rdata, 32'hDEAD_BEEF);

    // Load extension
    preload(32'h30, 32'h80FF_7F01);
    access(1'b0, 2'b00, 1'b1, 32'h31, 32'h0);
    check("lb_31_sx", rdata, 32'h0000_007F);
    access(1'b0, 2'b00, 1'b1, 32'h32, 32'h0);
    check("lb_32_sx", rdata, 32'hFFFF_FFFF);
    access(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    check("lh_32_zx", rdata, 32'h0000_80FF);

    // Misaligned word load
    wc = wr_cnt;
    access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    check("mis_no_write", 32'(wr_cnt - wc), 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_rdata_kept", rdata, 32'h0000_80FF);
`else
    check("mis_aligned_down", rdata, 32'hDEAD_BEEF);
`endif

    // Back-to-back loads with req held high
    @(negedge clk);
    e = predict(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    sb.push_back(e);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    check("b2b_busy1", {31'd0, busy}, 32'd1);
    addr = 32'h30;
    e = predict(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    sb.push_back(e);
    @(posedge clk); #1;
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_rdata1", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("b2b_busy2", {31'd0, busy}, 32'd1);
    req = 1'b0;
    @(posedge clk); #1;
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_rdata2", rdata, 32'h80FF_7F01);

    // req pulse while busy is ignored
    preload(32'h50, 32'h0102_0304);
    preload(32'h60, 32'h0000_0000);
    wc = wr_cnt;
    @(negedge clk);
    e = predict(1'b1, 2'b00, 1'b0, 32'h50, 32'h55);
    sb.push_back(e);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h50; wdata = 32'h55;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h60; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("ign_done", {31'd0, done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ign_wr_count", 32'(wr_cnt - wc), 32'd1);
    check("ign_mem50", mem[20], 32'h0102_0355);
    check("ign_mem60", mem[24], 32'h0000_0000);

    // Reset during RMW_RD
    preload(32'h40, 32'hCAFE_F00D);
    wc = wr_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h41; wdata = 32'h77;
    @(posedge clk); #1;
    req = 1'b0;
    check("rstm_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstm_busy", {31'd0, busy}, 32'd0);
    check("rstm_memwrite", {31'd0, MemWrite}, 32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstm_mem", mem[16], 32'hCAFE_F00D);
    check("rstm_wr_count", 32'(wr_cnt - wc), 32'd0);

    // Random mixed traffic over a small window
    for (int i = 0; i < 4; i++) preload(32'h100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 15)), $urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check("rand_mem", mem[64 + i], ref_mem[64 + i]);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that acts as the initiator toward the 4 KiB word-addressed data memory. It turns CPU byte, halfword and word accesses into word-only memory transactions. Loads extract and sign- or zero-extend the addressed lane. Sub-word stores run a read-modify-write sequence because the memory writes whole words only. The block sits between the multicycle datapath's memory stage and the data memory, with a req/busy/done handshake on the CPU side.

## Interface
- No parameters.
- clk  in  1  clock; every state change happens on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  1  access request; sampled only while busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  2  access width: 00 = byte, 01 = halfword, 10 = word. 11 is treated as word.
- sign_ext  in  1  loads only: 1 = sign-extend the lane, 0 = zero-extend it.
- addr  in  32  CPU byte address.
- wdata  in  32  store data, taken from the low bits for sub-word stores.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load result; valid while done=1 for a load and held until the next load completes.
- misalign  out  1  one-cycle pulse together with done for a rejected access.
- DataAddr  out  32  memory address; latched addr with bits [1:0] forced to 0.
- WriteData  out  32  memory write data; registered.
- MemWrite  out  1  memory write enable; decoded from state, high only in STORE.
- ReadData  in  32  memory read data; combinational from DataAddr.

## Operation
- Byte lanes are little-endian.
  - Byte k occupies bits [8k+7:8k] of the word, where k = addr[1:0].
  - The halfword at addr[1]=h occupies bits [16h+15:16h].
- FSM states are IDLE, LOAD, RMW_RD and STORE.
- IDLE with req=1 latches addr, we, size, sign_ext and wdata, then branches:
  - Load → LOAD.
  - Word store → STORE, with WriteData set to wdata.
  - Byte or halfword store → RMW_RD.
- LOAD drives DataAddr, registers the extracted and extended lane of ReadData into rdata, pulses done, and returns to IDLE.
- RMW_RD captures ReadData, replaces the addressed lane with the low byte or halfword of wdata, loads the merged word into WriteData, then → STORE.
- STORE asserts MemWrite for exactly one cycle, pulses done, and returns to IDLE.
- req is ignored while busy=1; there is no queueing.
- A store never modifies rdata.
- Misalignment covers a halfword with addr[0]=1, or a word with addr[1:0]≠00.
- Reset values:
  - State is IDLE.
  - busy, done, misalign and MemWrite are 0.
  - rdata, DataAddr and WriteData are 0x00000000.

## Timing
- Edge E0 is the edge at which the request is accepted in IDLE.
- Load: LOAD occupies the cycle after E0. rdata is captured at E1, and done is high in the cycle after E1.
- Word store: MemWrite is high in the cycle after E0, the memory writes at E1, and done is high after E1.
- Sub-word store: RMW_RD follows E0, STORE follows E1, the memory writes at E2, and done is high after E2.
- busy drops in the same cycle done rises. A req held high during the done cycle is accepted at the next edge (back-to-back).
- A misaligned access stays in IDLE: done and misalign pulse in the cycle after E0, busy stays 0, and no memory access occurs.
- Reset asserted mid-operation forces IDLE asynchronously. MemWrite drops immediately and an in-flight RMW write is abandoned.

## Configuration
- LSU_MISALIGN_CHECK_EN
  - Defined: misaligned accesses are rejected as described in Operation.
  - Undefined: misalign is tied to 0 and the low address bits below the access width are ignored. A halfword uses addr[1] only; a word is fully aligned down. These accesses proceed normally.

## Test plan
- Word store then load:
  - Store 0xDEADBEEF to 0x10, then load a word from 0x10.
  - Required: MemWrite is high for one cycle with DataAddr=0x10, and rdata=0xDEADBEEF when done pulses.
- Sub-word store (RMW):
  - Memory holds 0x11223344 at 0x20; store byte 0xAB to 0x22.
  - Required: RMW_RD then STORE, WriteData=0x11AB3344, done two edges after acceptance.
- Load extension:
  - Memory holds 0x80FF7F01 at 0x30.
  - Byte load from 0x31 with sign_ext=1: rdata=0x0000007F.
  - Byte load from 0x32 with sign_ext=1: rdata=0xFFFFFFFF.
  - Halfword load from 0x32 with sign_ext=0: rdata=0x000080FF.
- Misalignment, macro defined: a word load from 0x13 gives done=misalign=1 one cycle later, MemWrite never rises and rdata is unchanged.
- Misalignment, macro undefined: the same word load from 0x13 reads 0x10.
- Back-to-back requests and ignored req: req is held high across two loads, and the second is accepted in the first's done cycle. A req pulse while busy is ignored.
- Reset mid-RMW: assert rst during RMW_RD of a byte store. Required: busy=0 and MemWrite=0 immediately, and memory is unchanged.
